uart_rx_frontend: RTL and testbench

Serial UART receiver that feeds the SRAM/SoC controller's byte-level rx handshake (rx_data_out, rx_valid, rx_enable, rx_ready).
- Oversamples the pad line, frames 8N1 bytes LSB-first and presents each byte in a one-deep holding register until the controller consumes it.
- Flags framing errors and overruns.

---
 rtl/uart_rx_frontend.sv | 255 +++++++++++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// ---------------------------------------------------------------------------
// uart_rx_frontend
//
// Serial UART receiver in front of the controller's byte-level rx handshake.
// It synchronizes the pad line and frames 8N1 bytes LSB-first, using mid-bit
// sampling driven by a baud counter. Each good byte is presented in a
// one-deep holding register until the controller consumes it with rx_ready.
// Framing errors and overruns are reported as single-cycle pulses.
//
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames.
// In that build, a PARITY state sits between DATA and STOP, and the extra
// output parity_err pulses instead of rx_valid when the parity check fails.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//   SYNC_STAGES   flops in the rx line synchronizer (>= 2)
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   uart_rx      asynchronous serial line from pad, idle high
//   rx_enable    controller permits reception; low aborts back to IDLE
//   rx_ready     controller consumes the held byte this cycle
//   rx_data_out  received byte, stable while rx_valid=1
//   rx_valid     holding register full
//   frame_err    1-cycle pulse: stop bit sampled low
//   overrun      1-cycle pulse: byte completed while holding register full
//   parity_err   (UART_RX_PARITY_EN only) 1-cycle pulse: parity mismatch
// ---------------------------------------------------------------------------
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 87,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    input  logic       rx_enable,
    input  logic       rx_ready,
    output logic [7:0] rx_data_out,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] HALF     = BAUD_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [BAUD_W-1:0] BIT_END  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE = BAUD_W'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    // Synchronizer: shifts toward the MSB. The last stage is the only copy of
    // the line that the state machine looks at.
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxs;

    assign rxs = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], uart_rx};
        end
    end

    logic [2:0]        state_reg,     state_next;
    logic [BAUD_W-1:0] baud_reg,      baud_next;
    logic [2:0]        bit_reg,       bit_next;
    logic [7:0]        shift_reg,     shift_next;
    logic [7:0]        data_reg,      data_next;
    logic              valid_reg,     valid_next;
    logic              frame_err_reg, frame_err_next;
    logic              overrun_reg,   overrun_next;
`ifdef UART_RX_PARITY_EN
    logic              parity_bad_reg, parity_bad_next;
    logic              parity_err_reg, parity_err_next;
`endif

    always_comb begin
        state_next     = state_reg;
        baud_next      = baud_reg;
        bit_next       = bit_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        valid_next     = valid_reg;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_next = parity_bad_reg;
        parity_err_next = 1'b0;
`endif

        // Consume. A commit on the same edge (STOP branch below) overrides
        // this and leaves the new byte valid.
        if (valid_reg && rx_ready) begin
            valid_next = 1'b0;
        end

        if (!rx_enable) begin
            // Abort: the partial byte is dropped silently. The holding
            // register is left alone.
            state_next = S_IDLE;
            baud_next  = '0;
            bit_next   = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (!rxs) begin
                        baud_next  = '0;
                        bit_next   = '0;
                        state_next = S_START;
                    end
                end

                S_START: begin
                    // Requalify the start bit half a bit in. This rejects
                    // short glitches and centres the later samples mid-bit.
                    if (baud_reg == HALF) begin
                        if (rxs) begin
                            state_next = S_IDLE;
                        end else begin
                            baud_next  = '0;
                            bit_next   = '0;
                            state_next = S_DATA;
                        end
                    end else begin
                        baud_next = baud_reg + BAUD_ONE;
                    end
                end

                S_DATA: begin
                    if (baud_reg == BIT_END) begin
                        baud_next  = '0;
                        shift_next = {rxs, shift_reg[7:1]};
                        bit_next   = bit_reg + 3'd1;
                        if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_next = S_PARITY;
`else
                            state_next = S_STOP;
`endif
                        end
                    end else begin
                        baud_next = baud_reg + BAUD_ONE;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    // Even parity: the data bits XORed with the parity bit
                    // must come out as zero.
                    if (baud_reg == BIT_END) begin
                        baud_next       = '0;
                        parity_bad_next = ^{shift_reg, rxs};
                        state_next      = S_STOP;
                    end else begin
                        baud_next = baud_reg + BAUD_ONE;
                    end
                end
`endif

                S_STOP: begin
                    if (baud_reg == BIT_END) begin
                        baud_next = '0;
                        if (!rxs) begin
                            // A stop error outranks a parity error.
                            frame_err_next = 1'b1;
                            state_next     = S_BREAK;
                        end else begin
                            // Back to IDLE at mid-stop. The half bit left
                            // over absorbs baud mismatch with the sender.
                            state_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (parity_bad_reg) begin
                                parity_err_next = 1'b1;
                            end else
`endif
                            if (!valid_reg || rx_ready) begin
                                data_next  = shift_reg;
                                valid_next = 1'b1;
                            end else begin
                                overrun_next = 1'b1;
                            end
                        end
                    end else begin
                        baud_next = baud_reg + BAUD_ONE;
                    end
                end

                S_BREAK: begin
                    // A line held low must go high before a new start edge
                    // is accepted.
                    if (rxs) begin
                        state_next = S_IDLE;
                    end
                end

                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            baud_reg       <= '0;
            bit_reg        <= '0;
            shift_reg      <= '0;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            baud_reg       <= baud_next;
            bit_reg        <= bit_next;
            shift_reg      <= shift_next;
            data_reg       <= data_next;
            valid_reg      <= valid_next;
            frame_err_reg  <= frame_err_next;
            overrun_reg    <= overrun_next;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= parity_bad_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    assign rx_data_out = data_reg;
    assign rx_valid    = valid_reg;
    assign frame_err   = frame_err_reg;
    assign overrun     = overrun_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frontend
//
// Scoreboard bench for uart_rx_frontend with CLKS_PER_BIT=8.
// Each frame the stimulus sends is judged by a frame-level model (good byte,
// overrun, framing error, parity error, or nothing on an abort), and the
// outcome is queued. A monitor samples the DUT on the falling clock edge,
// pops an expectation for every output event, and checks that a held byte
// stays put while it is not being consumed.
// Inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_frontend;

    localparam int CPB  = 8;
    localparam int SYNC = 2;
    localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;            // start + 8 data + parity + stop
`else
    localparam int NB = 10;            // start + 8 data + stop
`endif
    // Rising edges from the start-bit launch to the stop mid-sample edge:
    // SYNC to cross the synchronizer, 1 for IDLE to see it, HALF+1 to
    // requalify the start bit, then one full bit period per remaining bit.
    localparam int COMMIT_EDGE = SYNC + 1 + (HALF + 1) + (NB - 1) * CPB;

    localparam int EV_BYTE = 0;
    localparam int EV_OVR  = 1;
    localparam int EV_FERR = 2;
    localparam int EV_PERR = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic       rx_enable;
    logic       rx_ready;
    logic [7:0] rx_data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   model_held = 1'b0;

    always #5 clk = ~clk;

    uart_rx_frontend #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rx     (uart_rx),
        .rx_enable   (rx_enable),
        .rx_ready    (rx_ready),
        .rx_data_out (rx_data_out),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .overrun     (overrun)
    );

    function automatic string kind_name(input int k);
        case (k)
            EV_BYTE: return "byte";
            EV_OVR:  return "overrun";
            EV_FERR: return "frame_err";
            default: return "parity_err";
        endcase
    endfunction

    task automatic push_exp(input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_val(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
        end
    endtask

    task automatic check_event(input int kind, input logic [7:0] d);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got %s data=0x%02h, required no event", kind_name(kind), d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EV_BYTE && e.data !== d)) begin
                errors++;
                $display("FAIL event: got %s data=0x%02h, required %s data=0x%02h",
                         kind_name(kind), d, kind_name(e.kind), e.data);
            end else begin
                $display("txn t=%0t %s data=0x%02h ok", $time, kind_name(kind), d);
            end
        end
    endtask

    // Monitor. The rx_ready sampled on a falling edge is the value that the
    // following rising edge acts on.
    initial begin
        bit         pv = 1'b0;
        bit         pr = 1'b0;
        logic [7:0] pd = 8'h00;
        wait (rst_n === 1'b1);
        forever begin
            @(negedge clk);
            if (frame_err && overrun) begin
                checks++;
                errors++;
                $display("FAIL exclusive_flags: got frame_err=1 overrun=1, required not both");
            end
            if (rx_valid && (!pv || pr)) begin
                check_event(EV_BYTE, rx_data_out);
            end else if (pv && !pr) begin
                checks++;
                if (rx_valid !== 1'b1 || rx_data_out !== pd) begin
                    errors++;
                    $display("FAIL hold: got valid=%0b data=0x%02h, required valid=1 data=0x%02h",
                             rx_valid, rx_data_out, pd);
                end
            end
            if (frame_err) check_event(EV_FERR, 8'h00);
            if (overrun)   check_event(EV_OVR, 8'h00);
`ifdef UART_RX_PARITY_EN
            if (parity_err) check_event(EV_PERR, 8'h00);
`endif
            pv = rx_valid;
            pr = rx_ready;
            pd = rx_data_out;
        end
    end

    task automatic idle_bits(input int n);
        repeat (n * CPB) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one frame and queues what the frame-level rules say must happen.
    // The task is entered and left 1 time unit after a rising edge.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_bad,
                              input int low_ext, input bit ready_at_commit,
                              input bit abort, input int gap);
        logic bits [0:NB-1];
        if (abort) begin
            // nothing is reported for an aborted frame
        end else if (!stop_ok) begin
            push_exp(EV_FERR, 8'h00);
        end else if (par_bad) begin
            push_exp(EV_PERR, 8'h00);
        end else if (model_held && !ready_at_commit) begin
            push_exp(EV_OVR, 8'h00);
        end else begin
            push_exp(EV_BYTE, d);
            model_held = 1'b1;
        end

        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
`ifdef UART_RX_PARITY_EN
        bits[9] = (^d) ^ par_bad;
`endif
        bits[NB-1] = stop_ok;

        for (int c = 0; c < (NB + low_ext) * CPB; c++) begin
            uart_rx  = (c / CPB < NB) ? bits[c / CPB] : 1'b0;
            rx_ready = ready_at_commit && (c == COMMIT_EDGE - 1);
            // Drop the enable part-way through data bit 4.
            if (abort && c >= 5 * CPB + 3) rx_enable = 1'b0;
            @(posedge clk);
            #1;
        end
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        idle_bits(gap);
        rx_enable = 1'b1;
    endtask

    task automatic glitch(input int n);
        uart_rx = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
        idle_bits(2);
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready   = 1'b0;
        model_held = 1'b0;
        @(negedge clk);
        check_val("consume_clears_valid", int'(rx_valid), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: time limit reached, required bench completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int r;
        logic [7:0] d;
        rst_n     = 1'b0;
        uart_rx   = 1'b1;
        rx_enable = 1'b1;
        rx_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_rx_valid", int'(rx_valid), 0);
        check_val("reset_rx_data_out", int'(rx_data_out), 0);
        check_val("reset_frame_err", int'(frame_err), 0);
        check_val("reset_overrun", int'(overrun), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_bits(1);

        // Byte held with rx_ready low, then consumed.
        send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1);
        idle_bits(20);
        check_val("held_A5", int'(rx_data_out), 'hA5);
        consume();

        // Second byte while the first is still held -> overrun.
        send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1);
        send_frame(8'h7E, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2);
        check_val("overrun_keeps_3C", int'(rx_data_out), 'h3C);
        consume();

        // Consume on the very edge that commits the next byte.
        send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1);
        send_frame(8'h55, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1);
        check_val("replace_55", int'(rx_data_out), 'h55);
        consume();

        // Short glitch, then a real byte.
        glitch(3);
        send_frame(8'h81, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1);
        consume();

        // Stop bit low, line held low 20 bit times, then a good byte.
        send_frame(8'hF0, 1'b0, 1'b0, 20, 1'b0, 1'b0, 2);
        send_frame(8'h0F, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1);
        consume();

        // Enable dropped mid-frame, then a good byte.
        send_frame(8'h99, 1'b1, 1'b0, 0, 1'b0, 1'b1, 2);
        send_frame(8'h42, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1);
        consume();
`ifdef UART_RX_PARITY_EN
        send_frame(8'h42, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1);
`endif

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 1) consume();
            if (r == 0) begin
                send_frame(d, 1'b0, 1'b0, int'($urandom_range(0, 3)), 1'b0, 1'b0,
                           1 + int'($urandom_range(0, 1)));
            end else if (r == 1) begin
                send_frame(d, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1 + int'($urandom_range(0, 1)));
            end else if (r == 2) begin
                glitch(1 + int'($urandom_range(0, 2)));
                send_frame(d, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1);
            end else if (r == 3) begin
`ifdef UART_RX_PARITY_EN
                send_frame(d, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1);
`else
                send_frame(d, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1);
`endif
            end else begin
                send_frame(d, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1 + int'($urandom_range(0, 1)));
            end
        end

        idle_bits(3 * NB);
        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
